// File: rtl/if_pkg.sv
// Shared fetch/decode types: instruction and address widths, the NOP word and the
// buffered fetch entry consumed by decode.
package if_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instn;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  nextpc;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// Fetch-to-decode FIFO with registered full stall, first-word fall-through head output
// and a single-cycle flush that discards all wrong-path entries.
module if_id_queue
  import if_pkg::*;
#(
  parameter int unsigned        DEPTH = 2,
  parameter logic [INSTR_W-1:0] NOP   = NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [INSTR_W-1:0]       in_instn,
  input  logic [ADDR_W-1:0]        in_pc,
  output logic                     stall_flag,
  output logic                     out_valid,
  output logic [INSTR_W-1:0]       out_instn,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [ADDR_W-1:0]        out_nextpc,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  if_id_entry_t    mem_q [DEPTH];
  if_id_entry_t    head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            stall_q, stall_d;
  logic            push, pop;

  assign out_valid = (count_q != '0);
  assign push      = in_valid & ~stall_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // Flush wins: same-cycle push is dropped and pop is not a handshake.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
    stall_d = (count_d == FullCnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= '{instn: in_instn, pc: in_pc, nextpc: in_pc + PC_STEP};
    end
  end

  always_comb begin
    head = mem_q[rd_ptr_q];
    if (out_valid) begin
      out_instn  = head.instn;
      out_pc     = head.pc;
      out_nextpc = head.nextpc;
    end else begin
      out_instn  = NOP;
      out_pc     = '0;
      out_nextpc = '0;
    end
  end

  assign stall_flag = stall_q;
  assign count      = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: a queue model tracks expected entries, outputs are
// compared each cycle away from the clock edge and entries are retired on model pops.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 2;

  typedef struct {
    logic [31:0] instn;
    logic [31:0] pc;
    logic [31:0] nextpc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instn;
  logic [31:0] in_pc;
  logic        stall_flag;
  logic        out_valid;
  logic [31:0] out_instn;
  logic [31:0] out_pc;
  logic [31:0] out_nextpc;
  logic        out_ready;
  logic        flush;
  logic [$clog2(DEPTH):0] count;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  if_id_queue #(
    .DEPTH (DEPTH),
    .NOP   (32'h0000_0000)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_instn   (in_instn),
    .in_pc      (in_pc),
    .stall_flag (stall_flag),
    .out_valid  (out_valid),
    .out_instn  (out_instn),
    .out_pc     (out_pc),
    .out_nextpc (out_nextpc),
    .out_ready  (out_ready),
    .flush      (flush),
    .count      (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model state.
  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'(sb.size() != 0));
    check({tag, ".stall"}, 32'(stall_flag), 32'(sb.size() == DEPTH));
    check({tag, ".count"}, 32'(count), 32'(sb.size()));
    if (sb.size() != 0) begin
      check({tag, ".instn"},  out_instn,  sb[0].instn);
      check({tag, ".pc"},     out_pc,     sb[0].pc);
      check({tag, ".nextpc"}, out_nextpc, sb[0].nextpc);
    end else begin
      check({tag, ".instn"},  out_instn,  32'h0000_0000);
      check({tag, ".pc"},     out_pc,     32'h0);
      check({tag, ".nextpc"}, out_nextpc, 32'h0);
    end
  endtask

  // One clock: drive at negedge, check just after, update model at posedge.
  task automatic cycle(input string tag, input logic iv, input logic [31:0] instn,
                       input logic [31:0] pc, input logic rdy, input logic fl);
    bit do_push;
    bit do_pop;
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    in_instn  = instn;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    #1;
    check_outputs(tag);
    do_pop  = (sb.size() != 0) && rdy;
    do_push = iv && (sb.size() != DEPTH);
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        e.instn  = instn;
        e.pc     = pc;
        e.nextpc = pc + 32'd4;
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_instn  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #12;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Single push, one-cycle latency, then empty again.
    cycle("t1.push", 1'b1, 32'h8C01_0004, 32'h0000_0000, 1'b1, 1'b0);
    cycle("t1.head", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle("t1.nop",  1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill with decode stalled; third push ignored.
    for (int i = 0; i < 3; i++)
      cycle("t2.fill", 1'b1, 32'h1000_0000 + 32'(i), 32'(i * 4), 1'b0, 1'b0);
    cycle("t2.full", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle("t2.drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Streaming push+pop; count holds at 1 and pointers wrap.
    for (int i = 0; i < 10; i++)
      cycle("t3.stream", 1'b1, 32'h2000_0000 + 32'(i), 32'(i * 4), 1'b1, 1'b0);
    cycle("t3.tail", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle("t3.empty", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush beats same-cycle push and pop.
    cycle("t4.fill0", 1'b1, 32'h3000_0000, 32'h100, 1'b0, 1'b0);
    cycle("t4.fill1", 1'b1, 32'h3000_0001, 32'h104, 1'b0, 1'b0);
    cycle("t4.flush", 1'b1, 32'h3000_0002, 32'h108, 1'b1, 1'b1);
    cycle("t4.push40", 1'b1, 32'h3000_0040, 32'h40, 1'b0, 1'b0);
    cycle("t4.head", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // nextpc wraps to zero.
    cycle("t5.wrap", 1'b1, 32'h4000_0000, 32'hFFFF_FFFC, 1'b0, 1'b0);
    cycle("t5.head", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset with the queue full.
    cycle("t6.fill0", 1'b1, 32'h5000_0000, 32'h200, 1'b0, 1'b0);
    cycle("t6.fill1", 1'b1, 32'h5000_0001, 32'h204, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    check_outputs("t6.async");
    @(negedge clk);
    reset = 1'b1;
    cycle("t6.after", 1'b1, 32'h5000_0002, 32'h208, 1'b1, 1'b0);
    cycle("t6.head", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random mix of push, pop and occasional flush.
    for (int i = 0; i < 60; i++)
      cycle("rand", 1'($urandom_range(0, 1)), $urandom, $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    cycle("final", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
